// File: rtl/sp_mem_ctrl.sv
// Request/response front end for a single-port RAM with one-cycle registered read.
// Optional power-up zero sweep of the RAM when SP_MEM_CTRL_INIT_EN is defined.
module sp_mem_ctrl #(
    parameter int unsigned ABITS = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ABITS-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             mem_wren,
    output logic             mem_rden,
    output logic [ABITS-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    localparam int unsigned CNT_W = 2;

    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic             run_c;
    logic             acc_c;
    logic             push_c;
    logic             pop_c;
    logic [ABITS-1:0] init_addr_c;

`ifdef SP_MEM_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] init_addr_q, init_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // Sweep every address once, then hand over to normal operation.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + ABITS'(1);
            if (&init_addr_q) begin
                state_d = ST_RUN;
            end
        end
    end

    assign run_c       = (state_q == ST_RUN);
    assign busy        = (state_q == ST_INIT);
    assign init_addr_c = init_addr_q;
`else
    assign run_c       = 1'b1;
    assign busy        = 1'b0;
    assign init_addr_c = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign rsp_rdata = data0_q;

    always_comb begin
        rsp_valid = (cnt_q != '0);
        pop_c     = rsp_valid && rsp_ready;
        // Credit covers both the read in flight and the buffered responses.
        req_ready = run_c && !rst
                    && (((3'(pend_q) + 3'(cnt_q)) < 3'd2) || pop_c);
        acc_c     = req_valid && req_ready;

        mem_wren  = 1'b0;
        mem_rden  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (run_c) begin
                mem_addr  = req_addr;
                mem_wdata = req_wdata;
                mem_wren  = acc_c && req_we;
                mem_rden  = acc_c && !req_we;
            end else begin
                mem_wren  = 1'b1;
                mem_addr  = init_addr_c;
            end
        end

        pend_d  = mem_rden;
        push_c  = pend_q;

        cnt_d   = cnt_q;
        data0_d = data0_q;
        data1_d = data1_q;
        // Two-entry shift FIFO: data0 is always the head.
        case ({push_c, pop_c})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    data0_d = mem_rdata;
                end else begin
                    data1_d = mem_rdata;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    data0_d = mem_rdata;
                end else begin
                    data0_d = data1_q;
                    data1_d = mem_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sp_mem_ctrl.sv
// Self-checking bench for sp_mem_ctrl: RAM model plus a request-order reference model.
// Honors SP_MEM_CTRL_INIT_EN to match the DUT build.
module tb_sp_mem_ctrl;

    localparam int unsigned ABITS = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ABITS-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;
    logic             mem_wren;
    logic             mem_rden;
    logic [ABITS-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             busy;

    sp_mem_ctrl #(.ABITS(ABITS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_wren  (mem_wren),
        .mem_rden  (mem_rden),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM; rdata only updates on a read.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        if (mem_rden) mem_rdata <= ram[mem_addr];
    end

    // Reference model: memory image at accept time, plus ordered expected responses.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] q_data [$];
    int               q_cyc [$];
    int               cyc = 0;
    bit               in_run = 1'b0;
    int               init_idx = 0;
    int               checks = 0;
    int               errors = 0;

`ifdef SP_MEM_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_cyc.delete();
        init_idx = 0;
        in_run   = !INIT_EN;
    endtask

    task automatic drive(input bit v, input bit we, input int addr, input int data);
        req_valid = v;
        req_we    = we;
        req_addr  = ABITS'(addr);
        req_wdata = WIDTH'(data);
    endtask

    // One clock: check all outputs against the model at negedge, then advance.
    task automatic cycle(output bit o_acc, output bit o_rv, output logic [WIDTH-1:0] o_rd);
        bit exp_rv, exp_rr, pop, acc;
        @(negedge clk);
        exp_rv = 1'b0;
        if (q_data.size() != 0) exp_rv = (cyc >= q_cyc[0] + 2);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv) chk("rsp_rdata", 32'(rsp_rdata), 32'(q_data[0]));
        pop    = exp_rv && rsp_ready;
        exp_rr = in_run && ((q_data.size() < 2) || pop);
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("busy", 32'(busy), 32'(!in_run));
        acc = req_valid && exp_rr;
        if (in_run) begin
            chk("mem_wren", 32'(mem_wren), 32'(acc && req_we));
            chk("mem_rden", 32'(mem_rden), 32'(acc && !req_we));
            if (acc) begin
                chk("mem_addr", 32'(mem_addr), 32'(req_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(req_wdata));
            end
        end else begin
            chk("init_wren", 32'(mem_wren), 32'd1);
            chk("init_rden", 32'(mem_rden), 32'd0);
            chk("init_addr", 32'(mem_addr), 32'(init_idx));
            chk("init_wdata", 32'(mem_wdata), 32'd0);
            ref_mem[init_idx] = '0;
            init_idx++;
            if (init_idx == DEPTH) in_run = 1'b1;
        end
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_cyc.pop_front());
        end
        if (acc) begin
            if (req_we) begin
                ref_mem[req_addr] = req_wdata;
            end else begin
                q_data.push_back(ref_mem[req_addr]);
                q_cyc.push_back(cyc);
            end
        end
        o_acc = req_valid && req_ready;
        o_rv  = rsp_valid;
        o_rd  = rsp_rdata;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        bit a, v;
        logic [WIDTH-1:0] d;
        cycle(a, v, d);
    endtask

    // Asynchronous reset in the middle of a cycle, released just after the next edge.
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_mem_rden", 32'(mem_rden), 32'd0);
        chk("rst_busy", 32'(busy), 32'(INIT_EN));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit               a, v;
        logic [WIDTH-1:0] d;
        int               n, npop;
        logic [WIDTH-1:0] got;

        rsp_ready = 1'b1;
        drive(1'b1, 1'b0, 'hA, 'h3C);

        // Power-on reset values, with a live request presented on the inputs.
        @(negedge clk);
        chk("por_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("por_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("por_req_ready", 32'(req_ready), 32'd0);
        chk("por_mem_wren", 32'(mem_wren), 32'd0);
        chk("por_mem_rden", 32'(mem_rden), 32'd0);
        chk("por_mem_addr", 32'(mem_addr), 32'd0);
        chk("por_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("por_busy", 32'(busy), 32'(INIT_EN));
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 0, 0);

        if (INIT_EN) begin
            // Reset at sweep address 7 restarts from 0, then a full sweep.
            drive(1'b1, 1'b0, 2, 0);
            repeat (7) tick();
            rst_pulse();
            repeat (DEPTH) tick();
            drive(1'b0, 1'b0, 0, 0);
        end

        // Write then read-after-write of the same address.
        drive(1'b1, 1'b1, 3, 'hA5);
        cycle(a, v, d);
        chk("first_accept", 32'(a), 32'd1);
        drive(1'b1, 1'b0, 3, 0);
        cycle(a, v, d);
        chk("raw_accept", 32'(a), 32'd1);
        drive(1'b0, 1'b0, 0, 0);
        cycle(a, v, d);
        chk("raw_t2_valid", 32'(v), 32'd0);
        cycle(a, v, d);
        chk("raw_t3_valid", 32'(v), 32'd1);
        chk("raw_t3_data", 32'(d), 32'hA5);
        tick();

        // Preload then 16 back-to-back reads with the response side always ready.
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, 1'b1, i, i + 'h10);
            tick();
        end
        n = 0;
        npop = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, 1'b0, i, 0);
            cycle(a, v, d);
            if (a) n++;
            if (v) begin
                chk("stream_data", 32'(d), 32'(npop + 'h10));
                npop++;
            end
        end
        drive(1'b0, 1'b0, 0, 0);
        repeat (4) begin
            cycle(a, v, d);
            if (v) begin
                chk("stream_data", 32'(d), 32'(npop + 'h10));
                npop++;
            end
        end
        chk("stream_accepts", 32'(n), 32'd16);
        chk("stream_responses", 32'(npop), 32'd16);

        // Backpressure: only two reads fit while the response side stalls.
        rsp_ready = 1'b0;
        n = 0;
        npop = 0;
        repeat (6) begin
            drive(1'b1, 1'b0, n + 4, 0);
            cycle(a, v, d);
            if (a) n++;
        end
        chk("bp_accepts", 32'(n), 32'd2);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        repeat (12) begin
            if (n < 4) drive(1'b1, 1'b0, n + 4, 0);
            else drive(1'b0, 1'b0, 0, 0);
            cycle(a, v, d);
            if (a) n++;
            if (v) begin
                chk("bp_order", 32'(d), 32'(npop + 4 + 'h10));
                npop++;
            end
        end
        chk("bp_accepts_total", 32'(n), 32'd4);
        chk("bp_responses", 32'(npop), 32'd4);

        // Reset while one response is buffered and another read is in flight.
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 5, 0);
        tick();
        drive(1'b1, 1'b0, 6, 0);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_pulse();
        if (INIT_EN) repeat (DEPTH) tick();
        rsp_ready = 1'b1;
        npop = 0;
        repeat (4) begin
            cycle(a, v, d);
            if (v) npop++;
        end
        chk("post_rst_no_rsp", 32'(npop), 32'd0);
        drive(1'b1, 1'b0, 9, 0);
        tick();
        drive(1'b0, 1'b0, 0, 0);
        got = '1;
        npop = 0;
        repeat (4) begin
            cycle(a, v, d);
            if (v) begin
                got = d;
                npop++;
            end
        end
        chk("post_rst_rsp_count", 32'(npop), 32'd1);
        chk("post_rst_data", 32'(got), INIT_EN ? 32'h00 : 32'h19);

        // Randomized traffic against the reference model.
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 1'b0, 0, 0);
        rsp_ready = 1'b1;
        repeat (5) tick();
        chk("drain_valid", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
